// File: rtl/ads5404_cal_pkg.sv
// ads5404_cal_pkg
// Shared definitions for the ADS5404 input-delay calibration block:
//   - calibration FSM state enum
//   - tap width / tap count constants
//   - eye tracker record type
//   - center_tap(): converts a tracked eye (start, length) into the tap to apply
package ads5404_cal_pkg;

    localparam int TAP_W = 5;
    localparam int NTAPS = 32;
    // A run can cover all 32 taps, so the length needs one bit more than a tap
    localparam int LEN_W = TAP_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CHECK,
        EVAL,
        APPLY,
        NEXT,
        FIN
    } cal_state_e;

    typedef struct packed {
        logic [TAP_W-1:0] cur_start;
        logic [LEN_W-1:0] cur_len;
        logic [TAP_W-1:0] best_start;
        logic [LEN_W-1:0] best_len;
    } eye_track_t;

    // Middle of the widest eye. start+len never exceeds 32, so start+len/2
    // always fits back into a 5-bit tap.
    function automatic logic [TAP_W-1:0] center_tap(
        input logic [TAP_W-1:0] start,
        input logic [LEN_W-1:0] len,
        input logic [TAP_W-1:0] dflt
    );
        if (len == '0) begin
            return dflt;
        end
        return TAP_W'(LEN_W'(start) + (len >> 1));
    endfunction

endpackage

// File: rtl/ads5404_eye_tracker.sv
// ads5404_eye_tracker
// Finds the longest run of consecutive passing taps for one lane. Taps are
// presented in order 0..31, one per 'valid' pulse; the tracker counts them
// itself so it needs no tap input.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clear       - restart tracking (next valid is tap 0)
//   valid       - one tap result is present on 'pass'
//   pass        - the tap being reported passed
//   best_start  - first tap of the longest passing run seen so far
//   best_len    - length of that run (0 = no passing tap yet)
module ads5404_eye_tracker
    import ads5404_cal_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic             pass,
    output logic [TAP_W-1:0] best_start,
    output logic [LEN_W-1:0] best_len
);

    eye_track_t       trk_q, trk_d;
    logic [TAP_W-1:0] idx_q, idx_d;
    logic [TAP_W-1:0] run_start;
    logic [LEN_W-1:0] run_len;

    // The best run is refreshed as soon as the open run overtakes it, so a
    // run still open at tap 31 is already counted. Strict '>' keeps the
    // lowest start on equal lengths.
    always_comb begin
        trk_d     = trk_q;
        idx_d     = idx_q;
        run_start = trk_q.cur_start;
        run_len   = '0;
        if (clear) begin
            trk_d = '0;
            idx_d = '0;
        end else if (valid) begin
            idx_d = idx_q + 1'b1;
            if (pass) begin
                run_start       = (trk_q.cur_len == '0) ? idx_q : trk_q.cur_start;
                run_len         = trk_q.cur_len + 1'b1;
                trk_d.cur_start = run_start;
                trk_d.cur_len   = run_len;
                if (run_len > trk_q.best_len) begin
                    trk_d.best_start = run_start;
                    trk_d.best_len   = run_len;
                end
            end else begin
                trk_d.cur_len = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_q <= '0;
            idx_q <= '0;
        end else begin
            trk_q <= trk_d;
            idx_q <= idx_d;
        end
    end

    assign best_start = trk_q.best_start;
    assign best_len   = trk_q.best_len;

endmodule

// File: rtl/ads5404_idelay_cal.sv
// ads5404_idelay_cal
// Per-lane IDELAY calibration for the ADS5404 capture interface. While the
// ADC drives its test pattern, every lane is swept over taps 0..31; each tap
// is loaded, allowed to settle, then checked for CHECK_CYCLES cycles. The
// centre of the widest passing eye is loaded as the lane's final tap. The
// ovr and sync lanes get DEFAULT_TAP at the end.
// Ports:
//   clk, rst_n   - clock (also the IDELAY control clock), async active-low reset
//   start        - one-cycle calibration request (ignored while busy)
//   d_0, d_1     - captured first/second-edge words
//   idelay_val   - tap value in [4:0], upper bits zero
//   idelay_ctrl  - one-hot LD strobes: lanes 0..NBITS-1, ovr NBITS, sync NBITS+1
//   busy         - calibration in progress
//   done         - sticky completion flag
//   err          - sticky per-lane "no eye found" flags
//   lane_tap     - final tap per lane, 5 bits each
module ads5404_idelay_cal
    import ads5404_cal_pkg::*;
#(
    parameter int               NBITS         = 12,
    parameter int               SETTLE_CYCLES = 16,
    parameter int               CHECK_CYCLES  = 32,
    parameter int               DEFAULT_TAP   = 8,
    parameter logic [NBITS-1:0] PATTERN_0     = {NBITS{1'b0}},
    parameter logic [NBITS-1:0] PATTERN_1     = {NBITS{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NBITS-1:0]       d_0,
    input  logic [NBITS-1:0]       d_1,
    output logic [31:0]            idelay_val,
    output logic [15:0]            idelay_ctrl,
    output logic                   busy,
    output logic                   done,
    output logic [NBITS-1:0]       err,
    output logic [TAP_W*NBITS-1:0] lane_tap
);

    localparam int LANE_W  = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [TAP_W-1:0]  DEF_TAP    = TAP_W'(DEFAULT_TAP);
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(NBITS - 1);
    localparam logic [TAP_W-1:0]  LAST_TAP   = TAP_W'(NTAPS - 1);
    localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CHECK_END  = CNT_W'(CHECK_CYCLES - 1);
    localparam logic [15:0]       OVR_STB    = 16'd1 << NBITS;
    localparam logic [15:0]       SYNC_STB   = 16'd1 << (NBITS + 1);

    cal_state_e             state_q, state_d;
    logic [LANE_W-1:0]      lane_q;
    logic [TAP_W-1:0]       tap_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   fail_q;
    logic                   fin_q;
    logic                   busy_q;
    logic                   done_q;
    logic [NBITS-1:0]       err_q;
    logic [TAP_W*NBITS-1:0] lane_tap_q;
    logic [TAP_W-1:0]       val_hold_q;

    logic [TAP_W-1:0]       val_d;
    logic [15:0]            ctrl_d;
    logic                   trk_clear;
    logic                   trk_valid;
    logic [TAP_W-1:0]       best_start;
    logic [LEN_W-1:0]       best_len;
    logic [TAP_W-1:0]       final_tap;
    logic                   lane_bad;

    ads5404_eye_tracker u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (trk_clear),
        .valid      (trk_valid),
        .pass       (~fail_q),
        .best_start (best_start),
        .best_len   (best_len)
    );

    assign final_tap = center_tap(best_start, best_len, DEF_TAP);
    assign lane_bad  = (d_0[lane_q] != PATTERN_0[lane_q]) ||
                       (d_1[lane_q] != PATTERN_1[lane_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the Moore strobe outputs. idelay_val follows val_d,
    // which only departs from the held value while a strobe is driven.
    always_comb begin
        state_d   = state_q;
        val_d     = val_hold_q;
        ctrl_d    = '0;
        trk_clear = 1'b0;
        trk_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    trk_clear = 1'b1;
                end
            end
            LOAD: begin
                ctrl_d  = 16'd1 << lane_q;
                val_d   = tap_q;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_END) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (cnt_q == CHECK_END) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                trk_valid = 1'b1;
                state_d   = (tap_q == LAST_TAP) ? APPLY : LOAD;
            end
            APPLY: begin
                ctrl_d  = 16'd1 << lane_q;
                val_d   = final_tap;
                state_d = NEXT;
            end
            NEXT: begin
                if (lane_q == LAST_LANE) begin
                    state_d = FIN;
                end else begin
                    state_d   = LOAD;
                    trk_clear = 1'b1;
                end
            end
            FIN: begin
                ctrl_d = fin_q ? SYNC_STB : OVR_STB;
                val_d  = DEF_TAP;
                if (fin_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: lane/tap sequencing, settle/check counting, the sticky
    // result flags and the per-lane result table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q     <= '0;
            tap_q      <= '0;
            cnt_q      <= '0;
            fail_q     <= 1'b0;
            fin_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= '0;
            lane_tap_q <= {NBITS{DEF_TAP}};
            val_hold_q <= '0;
        end else begin
            val_hold_q <= val_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lane_q <= '0;
                        tap_q  <= '0;
                        cnt_q  <= '0;
                        fin_q  <= 1'b0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        err_q  <= '0;
                    end
                end
                LOAD: begin
                    cnt_q  <= '0;
                    fail_q <= 1'b0;
                end
                SETTLE: begin
                    cnt_q <= (cnt_q == SETTLE_END) ? '0 : cnt_q + 1'b1;
                end
                CHECK: begin
                    cnt_q <= (cnt_q == CHECK_END) ? '0 : cnt_q + 1'b1;
                    if (lane_bad) begin
                        fail_q <= 1'b1;
                    end
                end
                EVAL: begin
                    tap_q <= tap_q + 1'b1;
                end
                APPLY: begin
                    lane_tap_q[lane_q*TAP_W +: TAP_W] <= final_tap;
                    if (best_len == '0) begin
                        err_q[lane_q] <= 1'b1;
                    end
                end
                NEXT: begin
                    if (lane_q != LAST_LANE) begin
                        lane_q <= lane_q + 1'b1;
                        tap_q  <= '0;
                    end
                end
                FIN: begin
                    if (fin_q) begin
                        fin_q  <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        fin_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign idelay_val  = {{(32-TAP_W){1'b0}}, val_d};
    assign idelay_ctrl = ctrl_d;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign lane_tap    = lane_tap_q;

endmodule

// File: tb/tb_ads5404_idelay_cal.sv
// tb_ads5404_idelay_cal
// Drives the calibrator through an emulated set of IDELAY lanes: each lane
// remembers the tap last strobed into it, outputs noise for SETTLE_CYCLES
// after a load, then shows the test pattern only if that tap is inside the
// lane's pass map. Expected results come from a brute-force longest-run
// search over the pass maps and are queued when a run is started; a monitor
// pops and compares when 'done' rises.
module tb_ads5404_idelay_cal;

    localparam int NBITS  = 12;
    localparam int SETTLE = 16;
    localparam int CHECK  = 32;
    localparam int DEF    = 8;
    localparam int RUN_CYCLES = NBITS * (32 * (2 + SETTLE + CHECK) + 2) + 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] d_0   = '0;
    logic [11:0] d_1   = '0;
    logic [31:0] idelay_val;
    logic [15:0] idelay_ctrl;
    logic        busy;
    logic        done;
    logic [11:0] err;
    logic [59:0] lane_tap;

    ads5404_idelay_cal #(
        .NBITS         (NBITS),
        .SETTLE_CYCLES (SETTLE),
        .CHECK_CYCLES  (CHECK),
        .DEFAULT_TAP   (DEF),
        .PATTERN_0     (12'h000),
        .PATTERN_1     (12'hFFF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .d_0         (d_0),
        .d_1         (d_1),
        .idelay_val  (idelay_val),
        .idelay_ctrl (idelay_ctrl),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .lane_tap    (lane_tap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [59:0] lane_tap;
        logic [11:0] err;
    } exp_t;

    int   checks      = 0;
    int   failures    = 0;
    exp_t sb_q[$];

    logic [31:0] pass_map [NBITS];
    int          chan_tap [NBITS];
    int          chan_age [NBITS];
    bit          glitch_en = 1'b0;
    logic [11:0] pat0 = 12'h000;
    logic [11:0] pat1 = 12'hFFF;

    int          completions = 0;
    int          busy_cycles = 0;
    int          viol        = 0;
    bit          prev_done   = 1'b0;
    bit          prev_busy   = 1'b0;
    bit          have_first  = 1'b0;
    logic [20:0] first_stb   = '0;
    logic [20:0] hist1       = '0;
    logic [20:0] hist2       = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Brute-force reference: try every start, measure the run, keep the
    // first longest one.
    function automatic logic [4:0] refTap(input logic [31:0] m, output bit no_eye);
        int bs;
        int bl;
        int l;
        bs = 0;
        bl = 0;
        for (int s = 0; s < 32; s++) begin
            l = 0;
            while ((s + l) < 32 && m[s + l]) l++;
            if (l > bl) begin
                bl = l;
                bs = s;
            end
        end
        no_eye = (bl == 0);
        return no_eye ? 5'(DEF) : 5'(bs + bl / 2);
    endfunction

    // Queue the expected outcome (if this run should complete) and pulse start.
    task automatic applyStimulus(input bit expect_result);
        exp_t        e;
        bit          ne;
        logic [31:0] m;
        e = '0;
        for (int i = 0; i < NBITS; i++) begin
            m = pass_map[i];
            if (glitch_en && i == 3) m[9] = 1'b0;
            e.lane_tap[i*5 +: 5] = refTap(m, ne);
            e.err[i] = ne;
        end
        if (expect_result) sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitRun(input int target);
        int n;
        n = 0;
        while (completions < target && n < RUN_CYCLES + 200) begin
            @(negedge clk);
            n++;
        end
        if (completions < target) checkOutput("run_timeout", 64'(completions), 64'(target));
    endtask

    // Emulated IDELAY lanes feeding d_0/d_1.
    always @(negedge clk) begin
        logic [11:0] n0;
        logic [11:0] n1;
        logic [1:0]  flip;
        bit          good;
        n0 = d_0;
        n1 = d_1;
        for (int i = 0; i < NBITS; i++) begin
            if (idelay_ctrl[i]) begin
                chan_tap[i] = int'(idelay_val[4:0]);
                chan_age[i] = 0;
            end else if (chan_age[i] < 1000) begin
                chan_age[i]++;
            end
            if (chan_age[i] <= SETTLE) begin
                n0[i] = 1'($urandom);
                n1[i] = 1'($urandom);
            end else begin
                good = pass_map[i][chan_tap[i]] &&
                       !(glitch_en && i == 3 && chan_tap[i] == 9 && chan_age[i] == SETTLE + 11);
                flip = good ? 2'b00 : 2'($urandom_range(1, 3));
                n0[i] = pat0[i] ^ flip[0];
                n1[i] = pat1[i] ^ flip[1];
            end
        end
        d_0 = n0;
        d_1 = n1;
    end

    // Monitor: strobe invariants, busy length, strobe history, scoreboard pop.
    always @(negedge clk) begin
        exp_t e;
        if (idelay_val[31:5] != '0 || !$onehot0(idelay_ctrl) || idelay_ctrl[15:14] != 2'b00) viol++;
        if (busy && !prev_busy) begin
            busy_cycles = 0;
            have_first  = 1'b0;
            hist1       = '0;
            hist2       = '0;
            viol        = 0;
        end
        if (busy) busy_cycles++;
        if (idelay_ctrl != '0) begin
            if (!have_first) begin
                first_stb  = {idelay_ctrl, idelay_val[4:0]};
                have_first = 1'b1;
            end
            hist2 = hist1;
            hist1 = {idelay_ctrl, idelay_val[4:0]};
        end
        if (done && !prev_done && rst_n) begin
            completions++;
            if (sb_q.size() == 0) begin
                checkOutput("sb_nonempty", 64'(0), 64'(1));
            end else begin
                e = sb_q.pop_front();
                for (int i = 0; i < NBITS; i++)
                    checkOutput($sformatf("lane_tap[%0d]", i), 64'(lane_tap[i*5 +: 5]), 64'(e.lane_tap[i*5 +: 5]));
                checkOutput("err", 64'(err), 64'(e.err));
                checkOutput("busy_cycles", 64'(busy_cycles), 64'(RUN_CYCLES));
                checkOutput("first_strobe", 64'(first_stb), 64'({16'h0001, 5'd0}));
                checkOutput("fin_ovr", 64'(hist2), 64'({16'h1000, 5'(DEF)}));
                checkOutput("fin_sync", 64'(hist1), 64'({16'h2000, 5'(DEF)}));
                checkOutput("strobe_invariant_violations", 64'(viol), 64'(0));
                checkOutput("val_hold_after_done", 64'({idelay_ctrl, idelay_val}), 64'({16'h0, 32'(DEF)}));
            end
        end
        prev_done = done;
        prev_busy = busy;
    end

    initial begin
        logic [59:0] def_taps;
        int          n;
        for (int i = 0; i < NBITS; i++) begin
            pass_map[i] = '0;
            chan_tap[i] = 0;
            chan_age[i] = 1000;
            def_taps[i*5 +: 5] = 5'(DEF);
        end

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_err", 64'(err), 64'(0));
        checkOutput("rst_ctrl_val", 64'({idelay_ctrl, idelay_val}), 64'(0));
        checkOutput("rst_lane_tap", 64'(lane_tap), 64'(def_taps));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Run 1: every tap passes on every lane -> all lanes centre at 16
        for (int i = 0; i < NBITS; i++) pass_map[i] = 32'hFFFF_FFFF;
        applyStimulus(1'b1);
        checkOutput("start_sets_busy", 64'({busy, done}), 64'({1'b1, 1'b0}));
        waitRun(1);

        // Run 2 (aborted): reset asserted mid-CHECK of lane 5
        for (int i = 0; i < NBITS; i++) pass_map[i] = $urandom | (32'h1 << $urandom_range(0, 31));
        pass_map[0] = 32'h0FF0_001C;
        pass_map[3] = 32'h0000_7FE0;
        pass_map[7] = 32'h0;
        glitch_en   = 1'b1;
        applyStimulus(1'b0);
        n = 0;
        while (idelay_ctrl != 16'h0020 && n < 7 * 3300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("lane5_load_seen", 64'(idelay_ctrl), 64'(16'h0020));
        repeat (SETTLE + 6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_outputs", 64'({idelay_ctrl, busy, done}), 64'(0));
        checkOutput("abort_val_err", 64'({idelay_val, err}), 64'(0));
        checkOutput("abort_lane_tap", 64'(lane_tap), 64'(def_taps));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checkOutput("no_resume", 64'({busy, done, idelay_ctrl}), 64'(0));

        // Run 2: lane 0 eyes 2..4/20..27 -> 24; lane 3 eye 5..14 with a
        // glitch at tap 9 -> runs 5..8 and 10..14, the longer one gives 12;
        // lane 7 never passes -> err bit 7, tap 8. Extra starts while busy.
        applyStimulus(1'b1);
        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(100, 5000)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        waitRun(2);
        checkOutput("run2_err", 64'(err), 64'(12'h080));

        // Run 3: start after done clears done/err; lane 0 eyes 0..3/10..13
        // -> 2 (tie to lower start), lane 1 eye 28..31 -> 30, lane 3 -> 10.
        glitch_en = 1'b0;
        for (int i = 0; i < NBITS; i++) pass_map[i] = $urandom & $urandom;
        pass_map[0] = 32'h0000_3C0F;
        pass_map[1] = 32'hF000_0000;
        pass_map[3] = 32'h0000_7FE0;
        applyStimulus(1'b1);
        checkOutput("restart_clears", 64'({busy, done, err}), 64'({1'b1, 1'b0, 12'h000}));
        waitRun(3);
        checkOutput("run3_lane0", 64'(lane_tap[4:0]), 64'(2));
        checkOutput("run3_lane1", 64'(lane_tap[9:5]), 64'(30));
        checkOutput("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
